cmos_capture_data: RTL and testbench

Captures the 8-bit DVP stream from the OV5640 and assembles byte pairs into RGB565 pixels with a one-cycle valid strobe. Discards a fixed number of frames after reset while sensor registers settle. Checks each accepted frame against the active size (`cmos_h_pixel`, `cmos_v_pixel`) chosen by the picture-size stage. Sits between the camera pins and the DDR3 write path.

---
 rtl/cmos_capture_data.sv | 164 ++++++++++++++++
 tb/tb_cmos_capture_data.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cmos_capture_data.sv
// OV5640 DVP capture: registers the pins, discards WAIT_FRAME frames after reset,
// then packs byte pairs into RGB565 pixels. Define CMOS_FRAME_CHECK_EN for frame-size checking.
module cmos_capture_data #(
    parameter int WAIT_FRAME = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic [12:0] cmos_h_pixel,
    input  logic [12:0] cmos_v_pixel,
    output logic        cmos_frame_vsync,
    output logic        cmos_frame_href,
    output logic        cmos_frame_valid,
    output logic [15:0] cmos_frame_data,
    output logic        frame_done,
    output logic        size_err
);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_FRAME);

    typedef enum logic {S_WAIT, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        vs_d0_q, vs_d1_q, href_d0_q, href_d1_q;
    logic [7:0]  data_d0_q;
    logic        byte_flag_q, byte_flag_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] pix_q, pix_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        vs_rise, frame_val, pix_done, line_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d0_q   <= 1'b0;
            vs_d1_q   <= 1'b0;
            href_d0_q <= 1'b0;
            href_d1_q <= 1'b0;
            data_d0_q <= '0;
        end else begin
            vs_d0_q   <= cam_vsync;
            vs_d1_q   <= vs_d0_q;
            href_d0_q <= cam_href;
            href_d1_q <= href_d0_q;
            data_d0_q <= cam_data;
        end
    end

    assign vs_rise   = vs_d0_q & ~vs_d1_q;
    assign frame_val = (state_q == S_RUN);

    // The count is checked before incrementing, so exactly WAIT_FRAME frames are dropped.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (state_q == S_WAIT && vs_rise) begin
            if (wait_cnt_q == WAIT_CNT) state_d = S_RUN;
            else                        wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        pix_done    = frame_val & href_d0_q & byte_flag_q;
        byte_flag_d = frame_val & href_d0_q & ~byte_flag_q;
        hi_d        = hi_q;
        if (frame_val & href_d0_q & ~byte_flag_q) hi_d = data_d0_q;
        valid_d = pix_done;
        pix_d   = pix_done ? {hi_q, data_d0_q} : pix_q;
        done_d  = vs_rise & frame_val & line_seen;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_flag_q <= 1'b0;
            hi_q        <= '0;
            pix_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            byte_flag_q <= byte_flag_d;
            hi_q        <= hi_d;
            pix_q       <= pix_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

`ifdef CMOS_FRAME_CHECK_EN
    logic [12:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        err_q, err_d;
    logic        href_fall;

    assign href_fall = href_d1_q & ~href_d0_q;

    // Nothing is counted in WAIT, so the vsync that enters RUN sees cleared counters.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        err_d   = err_q;
        if (frame_val) begin
            if (pix_done) h_cnt_d = h_cnt_q + 13'd1;
            if (href_fall) begin
                if (h_cnt_q != cmos_h_pixel) err_d = 1'b1;
                h_cnt_d = '0;
                v_cnt_d = v_cnt_q + 13'd1;
            end
            if (vs_rise) begin
                if (v_cnt_q != cmos_v_pixel) err_d = 1'b1;
                v_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            err_q   <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            err_q   <= err_d;
        end
    end

    assign line_seen = (v_cnt_q != '0);
    assign size_err  = err_q;
`else
    logic seen_q, seen_d;
    logic unused_size;

    always_comb begin
        seen_d = vs_rise ? 1'b0 : (seen_q | (frame_val & href_d0_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seen_q <= 1'b0;
        else        seen_q <= seen_d;
    end

    assign line_seen   = seen_q;
    assign size_err    = 1'b0;
    assign unused_size = ^{cmos_h_pixel, cmos_v_pixel};
`endif

    assign cmos_frame_vsync = vs_d1_q & frame_val;
    assign cmos_frame_href  = href_d1_q & frame_val;
    assign cmos_frame_valid = valid_q;
    assign cmos_frame_data  = pix_q;
    assign frame_done       = done_q;

endmodule

// File: tb/tb_cmos_capture_data.sv
// Scoreboard bench for cmos_capture_data: random DVP frames, expected pixels and
// frame_done events queued by a frame-level model, checked by an independent monitor.
module tb_cmos_capture_data;
    localparam int WF = 2;
`ifdef CMOS_FRAME_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = '0;
    logic [12:0] h_pix = 13'd4;
    logic [12:0] v_pix = 13'd2;
    logic        cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, frame_done, size_err;
    logic [15:0] cmos_frame_data;

    cmos_capture_data #(.WAIT_FRAME(WF)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cam_vsync        (cam_vsync),
        .cam_href         (cam_href),
        .cam_data         (cam_data),
        .cmos_h_pixel     (h_pix),
        .cmos_v_pixel     (v_pix),
        .cmos_frame_vsync (cmos_frame_vsync),
        .cmos_frame_href  (cmos_frame_href),
        .cmos_frame_valid (cmos_frame_valid),
        .cmos_frame_data  (cmos_frame_data),
        .frame_done       (frame_done),
        .size_err         (size_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        int          t;
    } pix_t;

    pix_t pq[$];
    int   dq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // frame-level reference state: vsync rises since reset, lines in current frame, sticky error
    int vs_cnt = 0;
    int lines_in_frame = 0;
    bit exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    pix_t mp;
    int   mt;
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (cmos_frame_valid) begin
                if (pq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pix_unexpected: got %0h expected none (cycle %0d)", cmos_frame_data, cyc);
                end else begin
                    mp = pq.pop_front();
                    chk("pix_data", cmos_frame_data, mp.d);
                    chk("pix_time", cyc, mp.t);
                    chk("pix_href", cmos_frame_href, 1);
                end
            end
            if (frame_done) begin
                if (dq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mt = dq.pop_front();
                    chk("done_time", cyc, mt);
                    chk("done_vsync", cmos_frame_vsync, 1);
                end
            end
        end
    end

    task automatic send_vsync();
        @(negedge clk);
        cam_vsync = 1'b1;
        vs_cnt++;
        if (vs_cnt > WF + 1) begin
            if (lines_in_frame > 0) dq.push_back(cyc + 2);
            if (CHK && lines_in_frame != int'(v_pix)) exp_err = 1'b1;
        end
        lines_in_frame = 0;
        repeat (2) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_line(input int nbytes, input bit force_first);
        logic [7:0] b, hi;
        hi = '0;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            if (force_first && i < 2) b = (i == 0) ? 8'hF8 : 8'h1F;
            else                      b = 8'($urandom);
            cam_href = 1'b1;
            cam_data = b;
            if (i % 2 == 0)      hi = b;
            else if (vs_cnt > WF) pq.push_back('{d: {hi, b}, t: cyc + 2});
        end
        @(negedge clk);
        cam_href = 1'b0;
        cam_data = 8'($urandom);
        repeat (3) @(negedge clk);
        lines_in_frame++;
        if (CHK && vs_cnt > WF && nbytes / 2 != int'(h_pix)) exp_err = 1'b1;
    endtask

    task automatic send_frame(input int nlines, input int nbytes);
        send_vsync();
        for (int l = 0; l < nlines; l++) send_line(nbytes, 1'b0);
    endtask

    task automatic apply_reset(input string name);
        rst_n    = 1'b0;
        cam_href = 1'b0;
        cam_vsync = 1'b0;
        #1;
        chk(name, {cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data,
                   frame_done, size_err}, 0);
        pq.delete();
        dq.delete();
        vs_cnt = 0;
        lines_in_frame = 0;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b, hi;
        repeat (2) @(negedge clk);
        apply_reset("reset_outs");

        // two discarded frames, then the first captured frame opens with F81F
        send_frame(2, 8);
        send_frame(2, 8);
        send_vsync();
        send_line(8, 1'b1);
        send_line(8, 1'b0);
        send_vsync();
        chk("size_err_4x2", size_err, exp_err);

        for (int l = 0; l < 3; l++) send_line(8, 1'b0);
        send_vsync();
        chk("size_err_4x3", size_err, exp_err);

        // odd trailing byte dropped, next line starts a fresh pair
        send_line(7, 1'b0);
        send_line(8, 1'b0);
        send_vsync();
        chk("size_err_sticky", size_err, exp_err);

        // reset in the middle of a captured line
        hi = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b = 8'($urandom);
            cam_href = 1'b1;
            cam_data = b;
            if (i % 2 == 0) hi = b;
            else            pq.push_back('{d: {hi, b}, t: cyc + 2});
        end
        @(negedge clk);
        chk("pre_rst_href", cmos_frame_href, 1);
        apply_reset("midline_rst_outs");

        // after reset the discard window applies again; then random frames
        for (int f = 0; f < 10; f++) begin
            send_frame($urandom_range(0, 3), $urandom_range(1, 10));
            chk("size_err_rand", size_err, exp_err);
        end
        send_vsync();
        chk("size_err_rand_end", size_err, exp_err);

        // short line of three pixels in a clean captured frame
        @(negedge clk);
        apply_reset("reset_outs_2");
        send_frame(1, 8);
        send_frame(1, 8);
        send_vsync();
        send_line(6, 1'b0);
        chk("size_err_short_line", size_err, exp_err);
        send_line(8, 1'b0);
        send_vsync();

        repeat (6) @(negedge clk);
        chk("pix_left", pq.size(), 0);
        chk("done_left", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
